// File: rtl/notas_pkg.sv
`default_nettype none
// ============================================================================
// notas_pkg : shared note-bus widths, limits and player state encoding
// Revision  : 1.0
// ============================================================================
package notas_pkg;

    localparam int NUM_NOTAS = 12;
    localparam int VALOR_W   = 4;

    localparam logic [VALOR_W-1:0] VALOR_MAX = 4'd11;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        TOCA   = 2'd1,
        PAUSA  = 2'd2,
        FIM    = 2'd3
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/encoder_valor_nota.sv
`default_nettype none
// ============================================================================
// encoder_valor_nota : note value (0..11) to 12-bit one-hot note bus
// Revision           : 1.0
// ============================================================================
module encoder_valor_nota
    import notas_pkg::*;
(
    input  logic [VALOR_W-1:0]   valor,
    output logic [NUM_NOTAS-1:0] nota,
    output logic                 valido
);

    localparam logic [NUM_NOTAS-1:0] UM = NUM_NOTAS'(1);

    // Out-of-range values encode to silence so the bus can never carry two bits.
    always_comb begin
        valido = (valor <= VALOR_MAX);
        nota   = valido ? (UM << valor) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/reprodutor_nota.sv
`default_nettype none
// ============================================================================
// reprodutor_nota : plays one note on the one-hot bus, then a pause, then fim
// Revision        : 1.0
// ============================================================================
module reprodutor_nota
    import notas_pkg::*;
#(
    parameter int CICLOS_NOTA  = 1000,
    parameter int CICLOS_PAUSA = 250,
    parameter int CONT_W       = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 iniciar,
    input  logic                 parar,
    input  logic [VALOR_W-1:0]   valor,
    output logic                 pronto,
    output logic [NUM_NOTAS-1:0] nota,
    output logic                 tocando,
    output logic                 fim,
    output logic                 erro
);

    localparam logic [CONT_W-1:0] CARGA_NOTA  = CONT_W'(CICLOS_NOTA - 1);
    localparam logic [CONT_W-1:0] CARGA_PAUSA = CONT_W'((CICLOS_PAUSA > 0) ? CICLOS_PAUSA - 1 : 0);

    estado_t               estado;
    logic [CONT_W-1:0]     contador;
    logic [NUM_NOTAS-1:0]  nota_enc;
    logic                  valido;

    encoder_valor_nota u_encoder (
        .valor  (valor),
        .nota   (nota_enc),
        .valido (valido)
    );

    // The one-hot nota register doubles as the latched note value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= OCIOSO;
            contador <= '0;
            nota     <= '0;
            tocando  <= 1'b0;
            fim      <= 1'b0;
            erro     <= 1'b0;
            pronto   <= 1'b1;
        end else begin
            fim  <= 1'b0;
            erro <= 1'b0;
            if (parar && (estado != OCIOSO)) begin
                estado   <= OCIOSO;
                contador <= '0;
                nota     <= '0;
                tocando  <= 1'b0;
                pronto   <= 1'b1;
            end else begin
                case (estado)
                    OCIOSO: begin
                        if (iniciar) begin
                            if (valido) begin
                                estado   <= TOCA;
                                contador <= CARGA_NOTA;
                                nota     <= nota_enc;
                                tocando  <= 1'b1;
                                pronto   <= 1'b0;
                            end else begin
                                erro <= 1'b1;
                            end
                        end
                    end
                    TOCA: begin
                        if (contador == '0) begin
                            nota    <= '0;
                            tocando <= 1'b0;
                            if (CICLOS_PAUSA > 0) begin
                                estado   <= PAUSA;
                                contador <= CARGA_PAUSA;
                            end else begin
                                estado <= FIM;
                                fim    <= 1'b1;
                            end
                        end else begin
                            contador <= contador - 1'b1;
                        end
                    end
                    PAUSA: begin
                        if (contador == '0) begin
                            estado <= FIM;
                            fim    <= 1'b1;
                        end else begin
                            contador <= contador - 1'b1;
                        end
                    end
                    FIM: begin
                        estado <= OCIOSO;
                        pronto <= 1'b1;
                    end
                    default: begin
                        estado <= OCIOSO;
                        pronto <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
